// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, state encoding and buffer entry type for the fetch stage
package fetch_pkg;
    localparam int INST_W = 32;
    localparam int OPCODE_W = 7;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} fetch_state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous buffer of {pc, inst} entries with a single-cycle flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        rd_d = flush ? '0 : rd_q + AW'(pop);
        wr_d = flush ? '0 : wr_q + AW'(push);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            if (push && !flush) mem_q[wr_q] <= din;
        end
    end

    assign dout = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign count = cnt_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC and in-order imem requests, buffered hand-off to decode, redirect flush.
// FETCH_BYPASS_EN: forwards a kept response straight to decode when the buffer is empty.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst_data,
    output logic [31:0]         inst_pc,
    output logic [OPCODE_W-1:0] inst_opcode
);
    localparam int CW = $clog2(FIFO_DEPTH) + 2;

    fetch_state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, req_addr_q, req_addr_d;
    logic [CW-1:0] out_q, out_d, stale_q, stale_d, occ_d;
    logic req_valid_q, req_valid_d, req_stale_q, req_stale_d;
    logic acc, hold, keep, push_req, push, pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    fetch_entry_t head, rsp_entry, out_entry;

    assign acc = req_valid_q && imem_req_ready;
    assign hold = req_valid_q && !imem_req_ready;
    assign keep = imem_rsp_valid && stale_q == '0 && !redirect_valid;
    assign rsp_entry = {rsp_pc_q, imem_rsp_data};
`ifdef FETCH_BYPASS_EN
    assign out_entry = (fifo_empty && keep) ? rsp_entry : head;
    assign inst_valid = !fifo_empty || keep;
    assign push_req = keep && !(fifo_empty && inst_ready);
`else
    assign out_entry = head;
    assign inst_valid = !fifo_empty;
    assign push_req = keep;
`endif
    assign pop = !fifo_empty && inst_ready;
    assign push = push_req && (!fifo_full || pop);

    // A request still held at a redirect (req_stale) is charged to stale once accepted.
    always_comb begin
        out_d = out_q + CW'(acc) - CW'(imem_rsp_valid);
        occ_d = redirect_valid ? '0 : CW'(count) + CW'(push) - CW'(pop);
        stale_d = stale_q - CW'(imem_rsp_valid && stale_q != '0) + CW'(acc && req_stale_q);
        req_stale_d = req_stale_q && !acc;
        pc_d = (acc && !req_stale_q) ? pc_q + 32'd4 : pc_q;
        rsp_pc_d = keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        state_d = (state_q == FLUSH && stale_q != '0) ? FLUSH : FETCH;
        if (redirect_valid) begin
            stale_d = out_d;
            req_stale_d = hold;
            pc_d = word_align(redirect_pc);
            rsp_pc_d = word_align(redirect_pc);
            state_d = out_d != '0 ? FLUSH : FETCH;
        end
        req_valid_d = hold || (state_d == FETCH && out_d + occ_d < CW'(FIFO_DEPTH));
        req_addr_d = hold ? req_addr_q : pc_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_valid_q <= 1'b0;
            req_stale_q <= 1'b0;
            out_q <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            req_addr_q <= req_addr_d;
            req_valid_q <= req_valid_d;
            req_stale_q <= req_stale_d;
            out_q <= out_d;
            stale_q <= stale_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset_n(reset_n),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .din(rsp_entry),
        .dout(head),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(count)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr = req_addr_q;
    assign inst_data = out_entry.inst;
    assign inst_pc = out_entry.pc;
    assign inst_opcode = out_entry.inst[OPCODE_W-1:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench; decode must see program order restarting at each redirect
module tb_instruction_fetch;
    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc;
    logic [6:0]  inst_opcode;

    instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .inst_opcode(inst_opcode)
    );

    always #5 clock = ~clock;

    int passes = 0, checks = 0;
    int cyc = 0, last_due = 0, occ = 0, delivered = 0, idle = 0;
    int lat_lo = 1, lat_hi = 1, rdy_pct = 100, ird_pct = 100, redir_pm = 0;
    mreq_t mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_exp, refill_pc, req_exp;
    bit refill = 0, cur_rsp_stale = 0, pend_stale = 0, prev_hold = 0;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_redirect(input logic [31:0] p);
        redirect_valid = 1'b1;
        redirect_pc = p;
        refill = 1;
        refill_pc = {p[31:2], 2'b00};
    endtask

    task automatic fill_exp();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_exp);
            next_exp += 32'd4;
        end
    endtask

    task automatic step();
        mreq_t m;
        logic [31:0] p;
        @(posedge clock);
        cyc++;
        if (refill) begin
            exp_q.delete();
            next_exp = refill_pc;
            refill = 0;
        end
        fill_exp();
        #1;
        imem_rsp_valid = 1'b0;
        cur_rsp_stale = 0;
        imem_rsp_data = $urandom();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_word(m.addr);
            cur_rsp_stale = m.stale;
        end
        imem_req_ready = $urandom_range(99) < rdy_pct;
        inst_ready = $urandom_range(99) < ird_pct;
        redirect_valid = 1'b0;
        if ($urandom_range(999) < redir_pm) begin
            p = $urandom_range(1) != 0 ? 32'h0000_1000 + 32'($urandom_range(1023))
                                       : 32'hFFFF_FFE0 + 32'($urandom_range(31));
            do_redirect(p);
        end
    endtask

    task automatic wait_hs(output logic [31:0] pc, output bit ok);
        ok = 0;
        pc = '0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            @(negedge clock);
            if (inst_valid && inst_ready) begin
                pc = inst_pc;
                ok = 1;
            end
        end
    endtask

    task automatic reset_and_release();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc", inst_pc, 0);
        mem_q.delete();
        exp_q.delete();
        next_exp = RPC;
        fill_exp();
        req_exp = RPC;
        occ = 0;
        last_due = 0;
        pend_stale = 0;
        prev_hold = 0;
        refill = 0;
        reset_n = 1'b1;
        @(negedge clock);
        check("boot_no_req", imem_req_valid, 0);
        step();
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, RPC);
    endtask

    always @(negedge clock) begin : monitor
        bit acc, st, kept;
        int due;
        logic [31:0] e, w;
        if (reset_n) begin
            acc = imem_req_valid && imem_req_ready;
            if (prev_hold) begin
                check("req_hold_valid", imem_req_valid, 1);
                check("req_hold_addr", imem_req_addr, prev_addr);
            end
            if (acc) begin
                st = pend_stale || redirect_valid;
                if (!st) begin
                    check("req_addr", imem_req_addr, req_exp);
                    req_exp += 32'd4;
                end
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{imem_req_addr, due, st});
                pend_stale = 0;
            end
            kept = imem_rsp_valid && !cur_rsp_stale && !redirect_valid;
            if (kept) occ++;
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) check("exp_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    w = mem_word(e);
                    check("inst_pc", inst_pc, e);
                    check("inst_data", inst_data, w);
                    check("inst_opcode", {25'b0, inst_opcode}, {25'b0, w[6:0]});
                end
                occ--;
                delivered++;
                idle = 0;
            end else idle++;
            if (idle > 200) begin
                check("progress_stall", 32'(idle), 0);
                idle = 0;
            end
            if (redirect_valid) begin
                foreach (mem_q[i]) mem_q[i].stale = 1;
                pend_stale = imem_req_valid && !imem_req_ready;
                occ = 0;
                req_exp = {redirect_pc[31:2], 2'b00};
            end
            check("credit_bound", 32'(mem_q.size() + occ <= DEPTH), 1);
            prev_hold = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
        end
    end

    initial begin
        int d0;
        bit ok, hit;
        logic [31:0] pc;
        reset_and_release();

        d0 = delivered;
        repeat (30) step();
        check("wrap_stream_progress", 32'(delivered - d0 >= 5), 1);

        ird_pct = 0;
        repeat (10) step();
        check("stall_buffer_full", 32'(occ), DEPTH);
        check("stall_inst_valid", inst_valid, 1);
        ird_pct = 100;
        repeat (20) step();

        lat_lo = 3;
        lat_hi = 3;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            hit = mem_q.size() == 2;
        end
        check("two_in_flight_reached", 32'(hit), 1);
        do_redirect(32'h0000_0100);
        step();
        check("flush_no_req", imem_req_valid, 0);
        wait_hs(pc, ok);
        check("redir100_hs_seen", 32'(ok), 1);
        check("redir100_pc", pc, 32'h0000_0100);

        lat_lo = 1;
        lat_hi = 1;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            hit = imem_rsp_valid && imem_req_valid;
        end
        check("rsp_acc_overlap_reached", 32'(hit), 1);
        imem_req_ready = 1'b1;
        do_redirect(32'h0000_0203);
        wait_hs(pc, ok);
        check("redir203_hs_seen", 32'(ok), 1);
        check("redir203_pc", pc, 32'h0000_0200);

        lat_hi = 4;
        rdy_pct = 70;
        ird_pct = 70;
        redir_pm = 40;
        repeat (1500) step();

        redir_pm = 0;
        rdy_pct = 100;
        lat_hi = 1;
        ird_pct = 0;
        repeat (8) step();
        check("pre_reset_full", 32'(occ), DEPTH);
        check("pre_reset_inst_valid", inst_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_inst_valid", inst_valid, 0);
        check("async_rst_req_valid", imem_req_valid, 0);
        ird_pct = 100;
        reset_and_release();
        wait_hs(pc, ok);
        check("restart_hs_seen", 32'(ok), 1);
        check("restart_pc", pc, RPC);
        repeat (20) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
